// File: rtl/jtag_dtm_unit_pkg.sv
// Shared types and default constants for the JTAG debug transport unit.
// Optional DMI timeout is enabled by defining JTAG_DTM_TIMEOUT_EN.
package jtag_dbg_pkg;

    typedef enum logic [1:0] {
        OpNop   = 2'd0,
        OpRead  = 2'd1,
        OpWrite = 2'd2,
        OpRsvd  = 2'd3
    } dmi_op_e;

    typedef enum logic [1:0] {
        StatOk     = 2'd0,
        StatFailed = 2'd2,
        StatBusy   = 2'd3
    } dmi_stat_e;

    typedef enum logic [1:0] {
        DmiIdle = 2'd0,
        DmiReq  = 2'd1,
        DmiWait = 2'd2
    } dmi_state_e;

    typedef enum logic [1:0] {
        SelBypass = 2'd0,
        SelIdcode = 2'd1,
        SelDbgcs  = 2'd2,
        SelDmi    = 2'd3
    } dr_sel_e;

    localparam logic [7:0]  IrIdcodeDefault = 8'h01;
    localparam logic [7:0]  IrDbgcsDefault  = 8'h10;
    localparam logic [7:0]  IrDmiDefault    = 8'h11;
    localparam logic [31:0] IdcodeDefault   = 32'h1DEA_D3FF;

    // Only reads and writes launch bus traffic; nop and reserved do nothing.
    function automatic logic op_is_access(dmi_op_e op);
        return (op == OpRead) || (op == OpWrite);
    endfunction

endpackage

// File: rtl/jtag_dtm_unit_if.sv
// DMI request/response bus between the transport unit (master) and the debug module (slave).
interface jtag_dtm_unit_if #(
    parameter int unsigned ADDR_W = 7
);
    logic              dmi_req_valid;
    logic              dmi_req_ready;
    logic [ADDR_W-1:0] dmi_req_addr;
    logic [31:0]       dmi_req_data;
    logic              dmi_req_write;
    logic              dmi_rsp_valid;
    logic [31:0]       dmi_rsp_data;
    logic              dmi_rsp_err;

    modport master (
        output dmi_req_valid, dmi_req_addr, dmi_req_data, dmi_req_write,
        input  dmi_req_ready, dmi_rsp_valid, dmi_rsp_data, dmi_rsp_err
    );

    modport slave (
        input  dmi_req_valid, dmi_req_addr, dmi_req_data, dmi_req_write,
        output dmi_req_ready, dmi_rsp_valid, dmi_rsp_data, dmi_rsp_err
    );
endinterface

// File: rtl/jtag_dtm_unit_dmi_fsm.sv
// DMI handshake FSM: request latches, response capture and sticky status.
// Defining JTAG_DTM_TIMEOUT_EN adds a timeout that abandons a stalled transaction.
module jtag_dmi_fsm
    import jtag_dbg_pkg::*;
#(
    parameter int unsigned ADDR_W         = 7,
    parameter int unsigned TIMEOUT_CYCLES = 1024
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              launch,
    input  dmi_op_e           op,
    input  logic [ADDR_W-1:0] addr,
    input  logic [31:0]       data,
    input  logic              clear_stat,
    jtag_dtm_unit_if.master   dmi,
    output logic [ADDR_W-1:0] last_addr,
    output logic [31:0]       rsp_data,
    output logic [1:0]        sticky_stat,
    output logic              busy
);

    dmi_state_e        state_q;
    dmi_stat_e         stat_q;
    logic              req_valid_q;
    logic              req_write_q;
    logic [ADDR_W-1:0] req_addr_q;
    logic [31:0]       req_data_q;
    logic [31:0]       rsp_data_q;
    logic              busy_q;
    logic              access;

    assign access = launch && op_is_access(op);

`ifdef JTAG_DTM_TIMEOUT_EN
    localparam int unsigned CntW = $clog2(TIMEOUT_CYCLES + 1);
    logic [CntW-1:0] tmo_cnt_q;
`else
    localparam int unsigned unused_timeout = TIMEOUT_CYCLES;
`endif

    // Handshake FSM with registered bus outputs and sticky status.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= DmiIdle;
            stat_q      <= StatOk;
            req_valid_q <= 1'b0;
            req_write_q <= 1'b0;
            req_addr_q  <= '0;
            req_data_q  <= '0;
            rsp_data_q  <= '0;
            busy_q      <= 1'b0;
`ifdef JTAG_DTM_TIMEOUT_EN
            tmo_cnt_q   <= '0;
`endif
        end else begin
            if (clear_stat) stat_q <= StatOk;
            unique case (state_q)
                DmiIdle: begin
                    // A non-zero sticky status blocks new requests until cleared.
                    if (access && stat_q == StatOk) begin
                        req_addr_q  <= addr;
                        req_data_q  <= data;
                        req_write_q <= (op == OpWrite);
                        req_valid_q <= 1'b1;
                        busy_q      <= 1'b1;
                        state_q     <= DmiReq;
                    end
                end
                DmiReq: begin
                    if (dmi.dmi_req_ready) begin
                        req_valid_q <= 1'b0;
                        state_q     <= DmiWait;
                    end
                end
                DmiWait: begin
                    if (dmi.dmi_rsp_valid) begin
                        if (!req_write_q) rsp_data_q <= dmi.dmi_rsp_data;
                        if (dmi.dmi_rsp_err) stat_q <= StatFailed;
                        busy_q  <= 1'b0;
                        state_q <= DmiIdle;
                    end
                end
                default: begin
                    req_valid_q <= 1'b0;
                    busy_q      <= 1'b0;
                    state_q     <= DmiIdle;
                end
            endcase
            if (access && state_q != DmiIdle) stat_q <= StatBusy;
`ifdef JTAG_DTM_TIMEOUT_EN
            // Counter is held at zero in IDLE, so it restarts on every entry to REQ.
            if (state_q == DmiIdle) begin
                tmo_cnt_q <= '0;
            end else if (tmo_cnt_q == CntW'(TIMEOUT_CYCLES)) begin
                tmo_cnt_q   <= '0;
                req_valid_q <= 1'b0;
                busy_q      <= 1'b0;
                stat_q      <= StatFailed;
                state_q     <= DmiIdle;
            end else begin
                tmo_cnt_q <= tmo_cnt_q + CntW'(1);
            end
`endif
        end
    end

    assign dmi.dmi_req_valid = req_valid_q;
    assign dmi.dmi_req_addr  = req_addr_q;
    assign dmi.dmi_req_data  = req_data_q;
    assign dmi.dmi_req_write = req_write_q;
    assign last_addr         = req_addr_q;
    assign rsp_data          = rsp_data_q;
    assign sticky_stat       = stat_q;
    assign busy              = busy_q;

endmodule

// File: rtl/jtag_dtm_unit.sv
// JTAG debug transport unit: IDCODE, BYPASS, DBGCS and DMI data registers.
// Defining JTAG_DTM_TIMEOUT_EN enables the DMI transaction timeout.
module jtag_dtm_unit
    import jtag_dbg_pkg::*;
#(
    parameter int unsigned          IR_WIDTH       = 8,
    parameter logic [31:0]          IDCODE_VALUE   = IdcodeDefault,
    parameter logic [IR_WIDTH-1:0]  IR_IDCODE      = IR_WIDTH'(IrIdcodeDefault),
    parameter logic [IR_WIDTH-1:0]  IR_DBGCS       = IR_WIDTH'(IrDbgcsDefault),
    parameter logic [IR_WIDTH-1:0]  IR_DMI         = IR_WIDTH'(IrDmiDefault),
    parameter int unsigned          ADDR_W         = 7,
    parameter int unsigned          TIMEOUT_CYCLES = 1024
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                tdi,
    output logic                tdo,
    input  logic                capture_dr,
    input  logic                shift_dr,
    input  logic                update_dr,
    input  logic [IR_WIDTH-1:0] ir_out,
    jtag_dtm_unit_if.master     dmi,
    input  logic                halted,
    output logic                debug_req,
    output logic                dmi_busy
);

    localparam int unsigned DmiW = ADDR_W + 34;

    dr_sel_e           sel;
    logic              bypass_q;
    logic [31:0]       idcode_q;
    logic [31:0]       dbgcs_q;
    logic [DmiW-1:0]   dmi_q;
    logic              debug_req_q;
    logic              update_only;
    logic [ADDR_W-1:0] last_addr;
    logic [31:0]       rsp_data;
    logic [1:0]        sticky_stat;
    logic [1:0]        cap_stat;
    logic              busy;
    logic              unused_dbgcs;

    // Instruction decode; unknown codes fall back to BYPASS.
    always_comb begin
        sel = SelBypass;
        if (ir_out == IR_IDCODE)     sel = SelIdcode;
        else if (ir_out == IR_DBGCS) sel = SelDbgcs;
        else if (ir_out == IR_DMI)   sel = SelDmi;
    end

    // Update acts only when neither capture nor shift claims the cycle.
    assign update_only  = update_dr && !capture_dr && !shift_dr;
    assign cap_stat     = busy ? 2'd3 : sticky_stat;
    assign unused_dbgcs = ^dbgcs_q[31:2];

    // Data register capture/shift and DBGCS update.
    always_ff @(posedge clk) begin
        if (rst) begin
            bypass_q    <= 1'b0;
            idcode_q    <= '0;
            dbgcs_q     <= '0;
            dmi_q       <= '0;
            debug_req_q <= 1'b0;
        end else if (capture_dr) begin
            unique case (sel)
                SelBypass: bypass_q <= 1'b0;
                SelIdcode: idcode_q <= IDCODE_VALUE;
                SelDbgcs:  dbgcs_q  <= {28'b0, halted, sticky_stat, debug_req_q};
                SelDmi:    dmi_q    <= {last_addr, rsp_data, cap_stat};
            endcase
        end else if (shift_dr) begin
            unique case (sel)
                SelBypass: bypass_q <= tdi;
                SelIdcode: idcode_q <= {tdi, idcode_q[31:1]};
                SelDbgcs:  dbgcs_q  <= {tdi, dbgcs_q[31:1]};
                SelDmi:    dmi_q    <= {tdi, dmi_q[DmiW-1:1]};
            endcase
        end else if (update_dr && sel == SelDbgcs) begin
            debug_req_q <= dbgcs_q[0];
        end
    end

    // Serial output follows the LSB of whichever register is selected.
    always_comb begin
        tdo = 1'b0;
        unique case (sel)
            SelBypass: tdo = bypass_q;
            SelIdcode: tdo = idcode_q[0];
            SelDbgcs:  tdo = dbgcs_q[0];
            SelDmi:    tdo = dmi_q[0];
        endcase
    end

    jtag_dmi_fsm #(
        .ADDR_W         (ADDR_W),
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
    ) u_dmi_fsm (
        .clk         (clk),
        .rst         (rst),
        .launch      (update_only && sel == SelDmi),
        .op          (dmi_op_e'(dmi_q[1:0])),
        .addr        (dmi_q[DmiW-1:34]),
        .data        (dmi_q[33:2]),
        .clear_stat  (update_only && sel == SelDbgcs && dbgcs_q[1]),
        .dmi         (dmi),
        .last_addr   (last_addr),
        .rsp_data    (rsp_data),
        .sticky_stat (sticky_stat),
        .busy        (busy)
    );

    assign debug_req = debug_req_q;
    assign dmi_busy  = busy;

endmodule

// File: tb/tb_jtag_dtm_unit.sv
// Directed bench for jtag_dtm_unit with a queue-based scoreboard.
module tb_jtag_dtm_unit;
    import jtag_dbg_pkg::*;

    localparam int unsigned AW  = 7;
    localparam int unsigned DW  = AW + 34;
    localparam logic [31:0] IDC = 32'h1DEA_D3FF;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       tdi = 1'b0;
    logic       tdo;
    logic       capture_dr = 1'b0;
    logic       shift_dr = 1'b0;
    logic       update_dr = 1'b0;
    logic [7:0] ir_out = 8'h00;
    logic       halted = 1'b0;
    logic       debug_req;
    logic       dmi_busy;

    int total = 0;
    int bad   = 0;
    logic [63:0] exp_q[$];
    logic [63:0] sout;

    always #5 clk = ~clk;

    jtag_dtm_unit_if #(.ADDR_W(AW)) dmi_if ();

    jtag_dtm_unit #(
        .IR_WIDTH       (8),
        .IDCODE_VALUE   (IDC),
        .IR_IDCODE      (8'h01),
        .IR_DBGCS       (8'h10),
        .IR_DMI         (8'h11),
        .ADDR_W         (AW),
        .TIMEOUT_CYCLES (1024)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .tdi        (tdi),
        .tdo        (tdo),
        .capture_dr (capture_dr),
        .shift_dr   (shift_dr),
        .update_dr  (update_dr),
        .ir_out     (ir_out),
        .dmi        (dmi_if),
        .halted     (halted),
        .debug_req  (debug_req),
        .dmi_busy   (dmi_busy)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic sb_chk(input string tag, input logic [63:0] obs);
        if (exp_q.size() == 0) begin
            total++;
            bad++;
            $error("FAIL %s: observed=%0h expected=<empty scoreboard>", tag, obs);
        end else begin
            chk(tag, obs, exp_q.pop_front());
        end
    endtask

    function automatic logic [63:0] dmi_word(logic [6:0] a, logic [31:0] d, logic [1:0] op);
        return {23'b0, a, d, op};
    endfunction

    function automatic logic [63:0] req_word(logic v, logic w, logic [6:0] a, logic [31:0] d);
        return {23'b0, v, w, a, d};
    endfunction

    function automatic logic [63:0] req_obs();
        return {23'b0, dmi_if.dmi_req_valid, dmi_if.dmi_req_write, dmi_if.dmi_req_addr,
                dmi_if.dmi_req_data};
    endfunction

    // Capture, shift n bits (LSB first), then update.
    task automatic scan(input logic [7:0] ir, input int n, input logic [63:0] din,
                        output logic [63:0] dout);
        dout = '0;
        ir_out = ir;
        capture_dr = 1'b1;
        tick();
        capture_dr = 1'b0;
        shift_dr = 1'b1;
        for (int i = 0; i < n; i++) begin
            dout[i] = tdo;
            tdi = din[i];
            tick();
        end
        shift_dr = 1'b0;
        update_dr = 1'b1;
        tick();
        update_dr = 1'b0;
    endtask

    task automatic ready_pulse();
        dmi_if.dmi_req_ready = 1'b1;
        tick();
        dmi_if.dmi_req_ready = 1'b0;
    endtask

    task automatic respond(input logic [31:0] d, input logic err);
        dmi_if.dmi_rsp_valid = 1'b1;
        dmi_if.dmi_rsp_data  = d;
        dmi_if.dmi_rsp_err   = err;
        tick();
        dmi_if.dmi_rsp_valid = 1'b0;
        dmi_if.dmi_rsp_err   = 1'b0;
    endtask

    initial begin
        dmi_if.dmi_req_ready = 1'b0;
        dmi_if.dmi_rsp_valid = 1'b0;
        dmi_if.dmi_rsp_data  = '0;
        dmi_if.dmi_rsp_err   = 1'b0;
        tick();
        tick();
        chk("reset_flags", {59'b0, tdo, dmi_if.dmi_req_valid, dmi_if.dmi_req_write,
                            debug_req, dmi_busy}, 64'h0);
        chk("reset_bus", {25'b0, dmi_if.dmi_req_addr, dmi_if.dmi_req_data}, 64'h0);
        rst = 1'b0;

        // IDCODE shifts out LSB first.
        exp_q.push_back({32'b0, IDC});
        scan(8'h01, 32, 64'h0, sout);
        sb_chk("idcode", sout);

        // Unknown IR selects the 1-bit bypass: one cycle of delay.
        exp_q.push_back(64'b010);
        scan(8'h55, 3, 64'b101, sout);
        sb_chk("bypass", sout);

        // Write with a stalled request.
        repeat (3) exp_q.push_back(req_word(1'b1, 1'b1, 7'h10, 32'hCAFE_F00D));
        scan(8'h11, DW, dmi_word(7'h10, 32'hCAFE_F00D, 2'd2), sout);
        for (int k = 0; k < 3; k++) begin
            sb_chk("write_req_stall", req_obs());
            tick();
        end
        ready_pulse();
        chk("write_wait", {62'b0, dmi_if.dmi_req_valid, dmi_busy}, 64'b01);
        respond(32'h5555_AAAA, 1'b0);
        chk("write_idle", {63'b0, dmi_busy}, 64'b0);
        exp_q.push_back(dmi_word(7'h10, 32'h0, 2'd0));
        scan(8'h11, DW, 64'h0, sout);
        sb_chk("write_capture", sout);

        // Read returns data on the next capture.
        exp_q.push_back(req_word(1'b1, 1'b0, 7'h04, 32'h0));
        scan(8'h11, DW, dmi_word(7'h04, 32'h0, 2'd1), sout);
        sb_chk("read_req", req_obs());
        ready_pulse();
        respond(32'h1234_5678, 1'b0);
        exp_q.push_back(dmi_word(7'h04, 32'h1234_5678, 2'd0));
        scan(8'h11, DW, 64'h0, sout);
        sb_chk("read_capture", sout);

        // Access while WAIT sets sticky busy.
        scan(8'h11, DW, dmi_word(7'h08, 32'h0, 2'd1), sout);
        ready_pulse();
        exp_q.push_back(dmi_word(7'h08, 32'h1234_5678, 2'd3));
        scan(8'h11, DW, dmi_word(7'h09, 32'h0, 2'd1), sout);
        sb_chk("busy_capture", sout);
        respond(32'hAAAA_5555, 1'b0);
        chk("busy_done", {63'b0, dmi_busy}, 64'b0);
        exp_q.push_back(dmi_word(7'h08, 32'hAAAA_5555, 2'd3));
        scan(8'h11, DW, dmi_word(7'h20, 32'h1, 2'd2), sout);
        sb_chk("sticky_busy", sout);
        chk("sticky_drop", {62'b0, dmi_if.dmi_req_valid, dmi_busy}, 64'b0);
        scan(8'h10, 32, 64'h2, sout);
        exp_q.push_back(dmi_word(7'h08, 32'hAAAA_5555, 2'd0));
        scan(8'h11, DW, 64'h0, sout);
        sb_chk("cleared", sout);
        exp_q.push_back(req_word(1'b1, 1'b1, 7'h20, 32'h1));
        scan(8'h11, DW, dmi_word(7'h20, 32'h1, 2'd2), sout);
        sb_chk("relaunch", req_obs());
        ready_pulse();
        respond(32'h0, 1'b0);

        // Error response latches failed status.
        scan(8'h11, DW, dmi_word(7'h30, 32'h0, 2'd1), sout);
        ready_pulse();
        respond(32'hDEAD_BEEF, 1'b1);
        exp_q.push_back(dmi_word(7'h30, 32'hDEAD_BEEF, 2'd2));
        scan(8'h11, DW, 64'h0, sout);
        sb_chk("err_capture", sout);
        scan(8'h10, 32, 64'h2, sout);

        // DBGCS halt request and status readback.
        scan(8'h10, 32, 64'h1, sout);
        chk("debug_req_set", {63'b0, debug_req}, 64'b1);
        halted = 1'b1;
        exp_q.push_back(64'h9);
        scan(8'h10, 32, 64'h1, sout);
        sb_chk("dbgcs_capture", sout);

        // Reset in the middle of REQ.
        scan(8'h11, DW, dmi_word(7'h11, 32'h0, 2'd1), sout);
        chk("req_before_rst", {63'b0, dmi_if.dmi_req_valid}, 64'b1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("after_rst", {61'b0, dmi_if.dmi_req_valid, debug_req, dmi_busy}, 64'b0);
        exp_q.push_back(dmi_word(7'h00, 32'h0, 2'd0));
        scan(8'h11, DW, 64'h0, sout);
        sb_chk("post_rst_dmi", sout);

`ifdef JTAG_DTM_TIMEOUT_EN
        scan(8'h11, DW, dmi_word(7'h05, 32'h0, 2'd1), sout);
        repeat (1100) tick();
        chk("timeout_idle", {62'b0, dmi_if.dmi_req_valid, dmi_busy}, 64'b0);
        exp_q.push_back(dmi_word(7'h05, 32'h0, 2'd2));
        scan(8'h11, DW, 64'h0, sout);
        sb_chk("timeout_stat", sout);
`endif

        chk("sb_empty", 64'(exp_q.size()), 64'h0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/jtag_dtm_unit.md
Name: jtag_dtm_unit

Overview:
- Parametrised next-generation JTAG debug transport block, driven by the TAP controller's capture/shift/update strobes and decoded IR.
- Provides IDCODE, a true 1-bit BYPASS, a debug control/status register (DBGCS) and a DMI access register.
- The DMI access register launches read/write transactions to the on-chip debug module over a valid/ready request plus response handshake.
- Fully synchronous to clk; the TAP is assumed already synchronised into the clk domain.

Parameters:
IR_WIDTH, 8, instruction register width
IDCODE_VALUE, 32'h1DEA_D3FF, value captured by IDCODE; bit 0 must be 1
IR_IDCODE, 8'h01, IDCODE opcode (IR_WIDTH bits)
IR_DBGCS, 8'h10, DBGCS opcode
IR_DMI, 8'h11, DMI access opcode
ADDR_W, 7, DMI address width
TIMEOUT_CYCLES, 1024, DMI timeout limit (used only with the optional feature)

Ports:
clk  in  1  system clock
rst  in  1  synchronous active-high reset
tdi  in  1  serial data in
tdo  out  1  serial data out, combinational from the selected DR LSB
capture_dr  in  1  capture strobe, one cycle
shift_dr  in  1  shift enable, one bit per cycle
update_dr  in  1  update strobe, one cycle
ir_out  in  IR_WIDTH  current instruction
dmi_req_valid  out  1  request valid
dmi_req_ready  in  1  request accepted
dmi_req_addr  out  ADDR_W  request address
dmi_req_data  out  32  write data
dmi_req_write  out  1  1 = write, 0 = read
dmi_rsp_valid  in  1  response strobe
dmi_rsp_data  in  32  read data
dmi_rsp_err  in  1  response error
halted  in  1  core halted status
debug_req  out  1  halt request to core
dmi_busy  out  1  DMI FSM not IDLE

Behaviour:
- Reset (rst high at a clk edge): every output 0; all shift registers, stored data and sticky status cleared; FSM returns to IDLE. Applies mid-transaction: dmi_req_valid drops on the cycle after the reset edge.
- DR selection by ir_out:
  - IDCODE: 32-bit register.
  - DBGCS: 32-bit register.
  - DMI: ADDR_W+34 bits, laid out {addr, data[31:0], op[1:0]} with op in the LSBs.
  - Any other code: BYPASS (1-bit register).
- Strobe priority per cycle: capture_dr > shift_dr > update_dr; lower-priority strobes are ignored when a higher one is asserted.
- Capture loads the selected register:
  - IDCODE: IDCODE_VALUE.
  - BYPASS: 0.
  - DBGCS: {28'b0, halted, sticky_stat[1:0], debug_req}.
  - DMI: {last_addr, rsp_data, stat}, where stat = 3 while busy, otherwise sticky_stat.
- Shift: the selected register shifts right with tdi entering the MSB; tdo = selected register bit 0.
- DBGCS update:
  - bit0 written into debug_req (level, held until rewritten).
  - bit1 = 1 clears sticky_stat.
  - Other bits ignored.
- DMI update, op field: 0 = nop, 1 = read, 2 = write, 3 = reserved (treated as nop).
  - Read/write with FSM IDLE and sticky_stat == 0: latch addr/data/op, FSM goes to REQ the next cycle.
  - FSM busy: request dropped, sticky_stat := 3 (busy).
  - sticky_stat != 0: request dropped silently until cleared through DBGCS.
- FSM states and transitions:
  - IDLE: waits for a DMI update that launches a request.
  - REQ: dmi_req_valid = 1, address/data/write held stable; goes to WAIT when valid && ready in the same cycle.
  - WAIT: on dmi_rsp_valid, rsp_data := dmi_rsp_data (reads only; writes leave rsp_data unchanged); if dmi_rsp_err, sticky_stat := 2 (failed); returns to IDLE.
  - dmi_rsp_valid outside WAIT is ignored.
- Minimum transaction latency: update cycle → REQ 1 cycle → WAIT 1 cycle → IDLE on the response cycle + 1.
- dmi_busy = (state != IDLE), registered.
- last_addr updates only when a request is launched.

Optional Feature:
- Macro: JTAG_DTM_TIMEOUT_EN.
- With the macro defined:
  - A counter of clog2(TIMEOUT_CYCLES+1) bits runs while in REQ or WAIT.
  - It resets whenever the FSM enters REQ.
  - On reaching TIMEOUT_CYCLES: sticky_stat := 2, dmi_req_valid deasserts, FSM returns to IDLE.
  - A late dmi_rsp_valid after timeout is ignored.
- Without the macro: no counter; the FSM waits indefinitely.

Decomposition:
- Package jtag_dbg_pkg holds:
  - dmi_op_e (NOP/READ/WRITE/RSVD);
  - dmi_stat_e (OK=0, FAILED=2, BUSY=3);
  - dmi_state_e (IDLE/REQ/WAIT);
  - default IR opcode constants.
- One natural sub-module, jtag_dmi_fsm: handshake FSM, request latches, response capture, sticky status and the optional timeout.
- The top level keeps DR shift registers, capture/update decode and tdo mux.

Test Plan:
- Reset, IR=01, capture then 32 shifts → tdo sequence equals IDCODE_VALUE LSB-first (0x1DEAD3FF).
- IR=0x55 (unknown), capture, shift tdi pattern 1,0,1 → tdo = 0,1,0 (one-cycle bypass delay).
- IR=DMI, write op addr=0x10, data=0xCAFEF00D; ready held low 3 cycles → dmi_req_valid stays high with stable fields; ready pulse → WAIT; rsp_valid with err=0 → IDLE, next capture shows stat=0.
- Read addr=0x04, response data 0x12345678 → next DMI capture returns {0x04, 0x12345678, 0}.
- Second DMI update while WAIT → request dropped, capture stat=3; further ops ignored until DBGCS write bit1=1; then stat=0 and a new op launches.
- DBGCS write 0x1 → debug_req=1; with halted=1 capture reads bit3=1; rst asserted mid-REQ → dmi_req_valid=0 and debug_req=0 the cycle after. Timeout build: no ready for 1024 cycles → stat=2, FSM IDLE.
